// File: rtl/etc_pkg.sv
// Shared defaults and the FIFO entry layout for the event toggle capture block.
package etc_pkg;

    localparam int ETC_N_CH        = 2;
    localparam int ETC_CNT_W       = 32;
    localparam int ETC_TS_W        = 32;
    localparam int ETC_FIFO_DEPTH  = 16;
    localparam int ETC_SYNC_STAGES = 2;
    localparam int ETC_DROP_W      = 16;

    // One logged event: when it happened and which channels fired together.
    // Timestamp occupies the upper bits of the packed entry.
    typedef struct packed {
        logic [ETC_TS_W-1:0] timestamp;
        logic [ETC_N_CH-1:0] mask;
    } etc_entry_t;

endpackage

// File: rtl/etc_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A write into a full FIFO is
// accepted only when a pop happens in the same cycle; pops on empty are ignored.
module etc_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    // Extra MSB on each pointer distinguishes full from empty when indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);

    // Head entry presented combinationally; zero when nothing is stored.
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; clear wins over any write or pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; validity is tracked by the
        // pointers alone, and rd_data is masked to zero while empty.
        if (wr_ok && !clear) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/event_toggle_capture.sv
// Counts and timestamps transitions on asynchronous toggle lines. Each
// channel is synchronised, edge-detected against a history flop, qualified
// by mask/enable/priming, counted, and logged into an event FIFO.
module event_toggle_capture
    import etc_pkg::*;
#(
    parameter int N_CH        = ETC_N_CH,
    parameter int CNT_W       = ETC_CNT_W,
    parameter int TS_W        = ETC_TS_W,
    parameter int FIFO_DEPTH  = ETC_FIFO_DEPTH,
    parameter int SYNC_STAGES = ETC_SYNC_STAGES
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic [N_CH-1:0]               event_toggle,
    input  logic                          enable,
    input  logic                          clear,
    input  logic [N_CH-1:0]               ch_mask,
    output logic [N_CH*CNT_W-1:0]         cnt_out,
    input  logic                          fifo_rd_en,
    output logic [TS_W+N_CH-1:0]          fifo_rd_data,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [ETC_DROP_W-1:0]         drop_cnt
);

    localparam int PW = $clog2(SYNC_STAGES + 2);

    typedef struct packed {
        logic [TS_W-1:0] timestamp;
        logic [N_CH-1:0] mask;
    } entry_t;

    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
    logic [N_CH-1:0]                  history;
    logic [PW-1:0]                    prime_cnt;
    logic                             primed;
    logic [N_CH-1:0]                  edge_det;
    logic [N_CH-1:0]                  q;
    logic [TS_W-1:0]                  ts_q;
    logic [CNT_W-1:0]                 cnt_q [N_CH];
    logic                             wr_req;
    logic                             drop;
    entry_t                           wr_entry;

    // Synchroniser chain plus history flop; clear deliberately leaves these alone.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            sync_q  <= '0;
            history <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], event_toggle};
            history <= sync_q[SYNC_STAGES-1];
        end
    end

    // Priming: hold off detection until the chain and history have filled,
    // so a line that is already high at reset release is not seen as an edge.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN)  prime_cnt <= '0;
        else if (!primed)    prime_cnt <= prime_cnt + 1'b1;
    end

    assign primed   = (prime_cnt == PW'(SYNC_STAGES + 1));
    assign edge_det = sync_q[SYNC_STAGES-1] ^ history;
    assign q        = edge_det & ch_mask & {N_CH{enable & primed}};
    assign wr_req   = (|q) && !clear;
    assign drop     = wr_req && fifo_full && !fifo_rd_en;

    // Free-running timestamp, frozen while capture is disabled.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) ts_q <= '0;
        else if (clear)     ts_q <= '0;
        else if (enable)    ts_q <= ts_q + 1'b1;
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        // Saturating per-channel event counter.
        always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
            if (!S_AXI_ARESETN)                 cnt_q[i] <= '0;
            else if (clear)                     cnt_q[i] <= '0;
            else if (q[i] && (cnt_q[i] != '1))  cnt_q[i] <= cnt_q[i] + 1'b1;
        end
        assign cnt_out[i*CNT_W +: CNT_W] = cnt_q[i];
    end

    // Sticky overflow flag and saturating count of entries lost to a full FIFO.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clear) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign wr_entry.timestamp = ts_q;
    assign wr_entry.mask      = q;

    etc_sync_fifo #(
        .WIDTH (TS_W + N_CH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (S_AXI_ACLK),
        .rst_n   (S_AXI_ARESETN),
        .clear   (clear),
        .wr_en   (wr_req),
        .wr_data (wr_entry),
        .rd_en   (fifo_rd_en),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .level   (fifo_level)
    );

endmodule

// File: tb/tb_event_toggle_capture.sv
// Scoreboard bench: two instances share stimulus, one at default widths and
// one with 4-bit counters and timestamps to exercise saturation and wrap.
module tb_event_toggle_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  event_toggle;
    logic        enable;
    logic        clear;
    logic [1:0]  ch_mask;
    logic        fifo_rd_en;

    logic [63:0] cnt_a;
    logic [33:0] rd_a;
    logic        empty_a, full_a, ovf_a;
    logic [4:0]  level_a;
    logic [15:0] drop_a;

    logic [7:0]  cnt_b;
    logic [5:0]  rd_b;
    logic        empty_b, full_b, ovf_b;
    logic [4:0]  level_b;
    logic [15:0] drop_b;

    typedef struct {
        logic [31:0] ts;
        logic [1:0]  mask;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] ts_model;
    bit          auto_pop;
    bit          pop_req;
    int          n_vec  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    event_toggle_capture dut_a (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .event_toggle  (event_toggle),
        .enable        (enable),
        .clear         (clear),
        .ch_mask       (ch_mask),
        .cnt_out       (cnt_a),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (rd_a),
        .fifo_empty    (empty_a),
        .fifo_full     (full_a),
        .fifo_level    (level_a),
        .overflow      (ovf_a),
        .drop_cnt      (drop_a)
    );

    event_toggle_capture #(.CNT_W(4), .TS_W(4)) dut_b (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .event_toggle  (event_toggle),
        .enable        (enable),
        .clear         (clear),
        .ch_mask       (ch_mask),
        .cnt_out       (cnt_b),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (rd_b),
        .fifo_empty    (empty_b),
        .fifo_full     (full_b),
        .fifo_level    (level_b),
        .overflow      (ovf_b),
        .drop_cnt      (drop_b)
    );

    // Reference timestamp: counts enabled cycles since reset or clear.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      ts_model <= '0;
        else if (clear)  ts_model <= '0;
        else if (enable) ts_model <= ts_model + 32'd1;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: pops the FIFO head when asked and compares it with the scoreboard.
    initial begin
        exp_t e;
        fifo_rd_en = 1'b0;
        forever begin
            @(negedge clk);
            fifo_rd_en = 1'b0;
            if (rst_n && (auto_pop || pop_req)) begin
                pop_req    = 1'b0;
                fifo_rd_en = 1'b1;
                if (!empty_a) begin
                    if (sb.size() == 0) begin
                        check("unexpected_entry", 64'(rd_a), 64'h0);
                    end else begin
                        e = sb.pop_front();
                        check("entry_a", 64'(rd_a), 64'({e.ts, e.mask}));
                        check("entry_b", 64'(rd_b), 64'({e.ts[3:0], e.mask}));
                    end
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Flip the selected lines; expected entry carries the timestamp seen two
    // cycles later, when the edge reaches the detector.
    task automatic toggle(input logic [1:0] bits, input bit log_it);
        exp_t e;
        event_toggle = event_toggle ^ bits;
        if (log_it) begin
            e.ts   = ts_model + 32'd2;
            e.mask = bits & ch_mask;
            sb.push_back(e);
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic check_counts(input int c0, input int c1);
        check("cnt0_a", cnt_a[31:0], 64'(c0));
        check("cnt1_a", cnt_a[63:32], 64'(c1));
        check("cnt0_b", cnt_b[3:0], 64'((c0 > 15) ? 15 : c0));
        check("cnt1_b", cnt_b[7:4], 64'((c1 > 15) ? 15 : c1));
    endtask

    task automatic check_status(input int lvl, input bit ovf, input int drops);
        check("level_a", level_a, 64'(lvl));
        check("level_b", level_b, 64'(lvl));
        check("empty_a", empty_a, 64'(lvl == 0));
        check("empty_b", empty_b, 64'(lvl == 0));
        check("full_a", full_a, 64'(lvl == 16));
        check("full_b", full_b, 64'(lvl == 16));
        check("overflow_a", ovf_a, 64'(ovf));
        check("overflow_b", ovf_b, 64'(ovf));
        check("drop_a", drop_a, 64'(drops));
        check("drop_b", drop_b, 64'(drops));
    endtask

    initial begin
        rst_n        = 1'b0;
        event_toggle = 2'b11;
        ch_mask      = 2'b11;
        enable       = 1'b1;
        clear        = 1'b0;
        auto_pop     = 1'b0;
        pop_req      = 1'b0;

        // Reset state, then static-high lines across reset release.
        wait_cycles(3);
        check_counts(0, 0);
        check_status(0, 0, 0);
        check("rd_data_rst_a", 64'(rd_a), 64'h0);
        check("rd_data_rst_b", 64'(rd_b), 64'h0);
        rst_n = 1'b1;
        wait_cycles(100);
        check_counts(0, 0);
        check_status(0, 0, 0);

        // Five ch0 toggles, ten cycles apart, ch1 masked.
        ch_mask  = 2'b01;
        auto_pop = 1'b1;
        for (int k = 0; k < 5; k++) begin
            toggle(2'b01, 1'b1);
            wait_cycles(10);
        end
        wait_cycles(5);
        check_counts(5, 0);
        check_status(0, 0, 0);
        check("sb_after_five", 64'(sb.size()), 64'h0);

        // Both channels in the same cycle share one entry.
        ch_mask = 2'b11;
        toggle(2'b11, 1'b1);
        wait_cycles(6);
        check_counts(6, 1);
        check("sb_after_dual", 64'(sb.size()), 64'h0);

        // Fill past capacity without pops: 16 kept, 4 dropped.
        auto_pop = 1'b0;
        ch_mask  = 2'b01;
        pulse_clear();
        wait_cycles(2);
        for (int k = 0; k < 20; k++) begin
            toggle(2'b01, k < 16);
            wait_cycles(3);
        end
        wait_cycles(4);
        check_status(16, 1, 4);
        check_counts(20, 0);

        // Pop in the very cycle a new event is written while full.
        toggle(2'b01, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 pop_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_status(16, 1, 4);
        check_counts(21, 0);
        auto_pop = 1'b1;
        wait_cycles(25);
        check_status(0, 1, 4);
        check("sb_after_drain", 64'(sb.size()), 64'h0);

        // Pop on empty is ignored; the next entry still reads back correctly.
        auto_pop = 1'b0;
        wait_cycles(2);
        pop_req = 1'b1;
        wait_cycles(3);
        check_status(0, 1, 4);
        toggle(2'b01, 1'b1);
        wait_cycles(5);
        check_status(1, 1, 4);
        auto_pop = 1'b1;
        wait_cycles(4);
        check_status(0, 1, 4);
        check("sb_after_empty_pop", 64'(sb.size()), 64'h0);

        // Clear coinciding with a qualified event discards that event.
        auto_pop = 1'b0;
        toggle(2'b01, 1'b0);
        wait_cycles(5);
        check_status(1, 1, 4);
        check_counts(23, 0);
        toggle(2'b01, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        check_counts(0, 0);
        check_status(0, 0, 0);
        wait_cycles(5);
        check_status(0, 0, 0);
        auto_pop = 1'b1;
        toggle(2'b01, 1'b1);
        wait_cycles(6);
        check_counts(1, 0);
        check("sb_after_clear", 64'(sb.size()), 64'h0);

        // Enable low freezes counting; no deferred event when re-enabled.
        enable = 1'b0;
        toggle(2'b01, 1'b0);
        wait_cycles(6);
        check_counts(1, 0);
        check_status(0, 0, 0);
        enable = 1'b1;
        wait_cycles(6);
        check_counts(1, 0);
        check_status(0, 0, 0);

        // Reset mid-operation discards contents immediately.
        auto_pop = 1'b0;
        toggle(2'b01, 1'b0);
        wait_cycles(5);
        check_counts(2, 0);
        check_status(1, 0, 0);
        rst_n = 1'b0;
        #1;
        check_counts(0, 0);
        check_status(0, 0, 0);
        check("rd_data_midrst_a", 64'(rd_a), 64'h0);
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(10);
        check_counts(0, 0);
        check_status(0, 0, 0);
        check("sb_final", 64'(sb.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/event_toggle_capture.md
EVENT_TOGGLE_CAPTURE -- requirements
Module: event_toggle_capture

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of DUT event-toggle channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32, per-channel event counter width.
REQ-003 SHALL have parameter TS_W, default 32, timestamp width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, event FIFO entries (power of 2, >=4).
REQ-005 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (>=2).
REQ-006 S_AXI_ACLK  in  1  sole clock; all logic on rising edge.
REQ-007 S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-008 event_toggle  in  N_CH  asynchronous DUT toggle lines; every transition (either polarity) is one event.
REQ-009 enable  in  1  level; capture active when high.
REQ-010 clear  in  1  single-cycle synchronous clear of counters, timestamp, FIFO, overflow state.
REQ-011 ch_mask  in  N_CH  1 = channel counted and logged.
REQ-012 cnt_out  out  N_CH*CNT_W  per-channel counters, channel i at bits [i*CNT_W +: CNT_W].
REQ-013 fifo_rd_en  in  1  pop head entry.
REQ-014 fifo_rd_data  out  TS_W+N_CH  head entry {timestamp, event mask}, first-word-fall-through.
REQ-015 fifo_empty, fifo_full  out  1 each  FIFO status.
REQ-016 fifo_level  out  clog2(FIFO_DEPTH)+1  occupied entries.
REQ-017 overflow  out  1  sticky: an entry was dropped.
REQ-018 drop_cnt  out  16  dropped entries, saturating at 0xFFFF.

Function
REQ-019 Each channel SHALL pass through SYNC_STAGES flops, then a history flop; event_i = sync_out_i XOR history_i.
REQ-020 Event detection SHALL be suppressed for the first SYNC_STAGES+1 cycles after reset release (priming), so a static-high input yields no event.
REQ-021 Qualified event q_i = event_i AND ch_mask[i] AND enable AND primed.
REQ-022 Counter i SHALL increment by 1 on the edge following q_i, saturating at all-ones.
REQ-023 Input transition to counter update latency SHALL be SYNC_STAGES+1 cycles (+1 metastability uncertainty).
REQ-024 Timestamp SHALL be a free-running TS_W counter, incrementing every cycle while enable high, wrapping to 0.
REQ-025 When any q_i set, one FIFO entry {timestamp, q vector} SHALL be written; simultaneous channel events share one entry.
REQ-026 Write while full with no pop SHALL drop the entry, set overflow, increment drop_cnt; counters still increment.
REQ-027 Write and pop in same cycle while full SHALL both succeed; level unchanged.
REQ-028 Pop while empty SHALL be ignored; pointers and level unchanged.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty from extra MSB pointer bit.
REQ-030 clear SHALL take priority over an event and a pop in the same cycle; that event is discarded.
REQ-031 clear SHALL not reset synchroniser, history or priming state.
REQ-032 enable low SHALL freeze counters and timestamp; FIFO pops still served.

Reset
REQ-033 On S_AXI_ARESETN low: cnt_out=0, timestamp=0, FIFO empty (fifo_empty=1, fifo_full=0, fifo_level=0), fifo_rd_data=0, overflow=0, drop_cnt=0, sync/history flops=0, primed=0.
REQ-034 Reset asserted mid-operation SHALL discard all FIFO contents and counts immediately.

Structure
REQ-035 Package etc_pkg SHALL hold the entry struct type (timestamp, mask) and parameter defaults.
REQ-036 FIFO SHALL be sub-module etc_sync_fifo (single-clock, FWFT, parametrised width/depth).

Verification
REQ-037 Reset release with event_toggle=2'b11 static 100 cycles -> cnt_out=0, fifo_empty=1.
REQ-038 Ch0 toggles 5 times, spaced 10 cycles, mask=2'b01 -> cnt0=5, cnt1=0, 5 entries mask 2'b01, timestamps strictly increasing by 10.
REQ-039 Both channels toggle same cycle -> one entry mask 2'b11, both counters +1.
REQ-040 FIFO_DEPTH=16, 20 events no pops -> fifo_full=1, level=16, overflow=1, drop_cnt=4; then pop with simultaneous event -> level stays 16, drop_cnt=4.
REQ-041 clear asserted in same cycle as qualified event -> counters 0, FIFO empty, overflow 0; next toggle counts 1.
REQ-042 CNT_W=4, 20 toggles -> cnt=15 saturated; TS_W=4 -> timestamp wraps 15->0 in logged entries.
